// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised sequence detector: width helper,
// legal pattern-length range and the elaboration-time next-state table builder.
package seq_detect_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int ST_W_MAX    = 5;

  // Row k, column b: next state from Sk when bit b is accepted.
  typedef logic [PAT_LEN_MAX:0][1:0][ST_W_MAX-1:0] nxt_tbl_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // From Sk with bit b appended, the next state is the longest pattern prefix
  // that is also a suffix of (first k pattern bits, b). Row PAT_LEN gives the
  // overlapping failure link; the top reuses row 0 for non-overlapping mode.
  function automatic nxt_tbl_t build_nxt_tbl(input logic [PAT_LEN_MAX-1:0] pattern,
                                             input int pat_len);
    nxt_tbl_t             tbl;
    logic [PAT_LEN_MAX:0] s;
    int                   best;
    logic                 ok;
    tbl = '0;
    if (pat_len < PAT_LEN_MIN || pat_len > PAT_LEN_MAX) return tbl;
    for (int k = 0; k <= PAT_LEN_MAX; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k <= pat_len) begin
          s = '0;
          for (int i = 0; i < PAT_LEN_MAX; i++) begin
            if (i < k) s[i] = pattern[pat_len-1-i];
          end
          s[k] = (b != 0);
          best = 0;
          for (int j = 1; j <= PAT_LEN_MAX + 1; j++) begin
            if (j <= k + 1 && j <= pat_len) begin
              ok = 1'b1;
              for (int m = 0; m < PAT_LEN_MAX; m++) begin
                if (m < j && pattern[pat_len-1-m] != s[k+1-j+m]) ok = 1'b0;
              end
              if (ok) best = j;
            end
          end
          tbl[k][b] = ST_W_MAX'(best);
        end
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_detect_sat_cnt.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module seq_detect_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear_i)                     count_d = '0;
    else if (inc_i && count_q != '1) count_d = count_q + W'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised Moore serial pattern detector tracking the longest matched prefix.
// Optional match counter enabled by defining SEQ_DETECT_COUNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           din,
  input  logic                           overlap,
  input  logic                           clear,
  output logic                           match,
  output logic [clog2(PAT_LEN+1)-1:0]    progress,
  output logic [CNT_W-1:0]               match_count
);

  localparam int               ST_W    = clog2(PAT_LEN + 1);
  localparam nxt_tbl_t         NXT_TBL = build_nxt_tbl(PAT_LEN_MAX'(PATTERN), PAT_LEN);
  localparam logic [ST_W-1:0]  S_FULL  = ST_W'(PAT_LEN);

  logic [ST_W-1:0]     state_q;
  logic [ST_W-1:0]     state_d;
  logic [ST_W_MAX-1:0] row_idx;
  logic                hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  // Non-overlapping mode restarts from S0's row once a full match is held.
  always_comb begin
    state_d = state_q;
    row_idx = (state_q == S_FULL && !overlap) ? '0 : ST_W_MAX'(state_q);
    if (clear)         state_d = '0;
    else if (in_valid) state_d = NXT_TBL[row_idx][din][ST_W-1:0];
  end

  always_comb begin
    match    = (state_q == S_FULL);
    progress = state_q;
  end

  assign hit = !clear && in_valid && (state_d == S_FULL);

`ifdef SEQ_DETECT_COUNT_EN
  seq_detect_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .inc_i   (hit),
    .count_o (match_count)
  );
`else
  logic unused_hit;
  assign unused_hit  = hit;
  assign match_count = '0;
`endif

endmodule
